// File: rtl/aes_inv_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
// S-box tables are stored as constants; xtime-based multipliers serve InvMixColumns.
package aes_inv_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ADDKEY,
        ROUND,
        FINAL,
        DONE
    } state_t;

    typedef logic [3:0] rnd_t;

    localparam rnd_t LAST_RND = rnd_t'(NR);

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Indices outside 1..10 only occur outside KEYEXP, where the value is discarded.
    function automatic logic [7:0] rcon(input rnd_t i);
        return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_final is set.
module aes_inv_round
    import aes_inv_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [7:0] w_sub [16];
    logic [7:0] w_mix [16];

    genvar c, r;
    for (c = 0; c < 4; c++) begin : g_col
        for (r = 0; r < 4; r++) begin : g_row
            // Row r rotates right by r columns, so byte (r,c) comes from column c-r.
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign w_sub[DST] = inv_sbox(i_state[127-8*SRC -: 8]) ^ i_round_key[127-8*DST -: 8];
            assign o_state[127-8*DST -: 8] = i_final ? w_sub[DST] : w_mix[DST];
        end
        assign w_mix[4*c+0] = gmul14(w_sub[4*c]) ^ gmul11(w_sub[4*c+1]) ^ gmul13(w_sub[4*c+2]) ^ gmul9(w_sub[4*c+3]);
        assign w_mix[4*c+1] = gmul9(w_sub[4*c]) ^ gmul14(w_sub[4*c+1]) ^ gmul11(w_sub[4*c+2]) ^ gmul13(w_sub[4*c+3]);
        assign w_mix[4*c+2] = gmul13(w_sub[4*c]) ^ gmul9(w_sub[4*c+1]) ^ gmul14(w_sub[4*c+2]) ^ gmul11(w_sub[4*c+3]);
        assign w_mix[4*c+3] = gmul11(w_sub[4*c]) ^ gmul13(w_sub[4*c+1]) ^ gmul9(w_sub[4*c+2]) ^ gmul14(w_sub[4*c+3]);
    end

endmodule

// File: rtl/aes_inv_core.sv
// AES-128 inverse cipher: 10-cycle key expansion, then one inverse round per cycle.
// Define AES_INV_KEY_CACHE_EN to reuse the expanded schedule when the key repeats.
module aes_inv_core
    import aes_inv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic         done,
    output logic [127:0] plaintext
);

    state_t       r_state;
    state_t       w_next;
    logic         r_load_q;
    rnd_t         r_cnt;
    logic [127:0] r_ct;
    logic [127:0] r_s;
    logic [127:0] r_rk [0:NR];
    logic         r_done;
    logic [127:0] r_pt;

    logic         w_start;
    logic         w_hit;
    rnd_t         w_kidx;
    logic [127:0] w_prev;
    logic [31:0]  w_last;
    logic [31:0]  w_temp;
    logic [31:0]  w_acc;
    logic [127:0] w_rk_next;
    logic [127:0] w_round_out;

    assign w_start   = load & ~r_load_q & ((r_state == IDLE) | (r_state == DONE));
    assign done      = r_done;
    assign plaintext = r_pt;

`ifdef AES_INV_KEY_CACHE_EN
    logic         r_rk_valid;
    logic [127:0] r_key_tag;

    assign w_hit = r_rk_valid & (key == r_key_tag);

    // The schedule is only trusted once a full expansion has completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rk_valid <= 1'b0;
            r_key_tag  <= '0;
        end else if (w_start && !w_hit) begin
            r_rk_valid <= 1'b0;
        end else if (r_state == KEYEXP && r_cnt == LAST_RND) begin
            r_rk_valid <= 1'b1;
            r_key_tag  <= r_rk[0];
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Forward expansion of round key r_cnt from round key r_cnt-1.
    always_comb begin
        w_kidx    = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        w_prev    = r_rk[w_kidx];
        w_last    = w_prev[31:0];
        w_temp    = {sbox(w_last[23:16]), sbox(w_last[15:8]), sbox(w_last[7:0]), sbox(w_last[31:24])}
                    ^ {rcon(r_cnt), 24'h0};
        w_acc     = w_temp;
        w_rk_next = '0;
        for (int j = 0; j < NK; j++) begin
            w_acc = w_acc ^ w_prev[127-32*j -: 32];
            w_rk_next[127-32*j -: 32] = w_acc;
        end
    end

    aes_inv_round u_round (
        .i_state     (r_s),
        .i_round_key (r_rk[r_cnt]),
        .i_final     (r_state == FINAL),
        .o_state     (w_round_out)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_next = w_hit ? ADDKEY : KEYEXP;
            KEYEXP:     if (r_cnt == LAST_RND) w_next = ADDKEY;
            ADDKEY:     w_next = ROUND;
            ROUND:      if (r_cnt == 4'd1) w_next = FINAL;
            FINAL:      w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_load_q <= 1'b0;
            r_cnt    <= '0;
            r_ct     <= '0;
            r_s      <= '0;
            r_done   <= 1'b0;
            r_pt     <= '0;
            for (int k = 0; k <= NR; k++) r_rk[k] <= '0;
        end else begin
            r_state  <= w_next;
            r_load_q <= load;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_ct    <= cyphertext;
                        r_rk[0] <= key;
                        r_done  <= 1'b0;
                        r_pt    <= '0;
                        r_cnt   <= 4'd1;
                    end
                end
                KEYEXP: begin
                    r_rk[r_cnt] <= w_rk_next;
                    if (r_cnt != LAST_RND) r_cnt <= r_cnt + 4'd1;
                end
                ADDKEY: begin
                    r_s   <= r_ct ^ r_rk[NR];
                    r_cnt <= LAST_RND - 4'd1;
                end
                ROUND: begin
                    r_s   <= w_round_out;
                    r_cnt <= r_cnt - 4'd1;
                end
                FINAL: begin
                    r_pt   <= w_round_out;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_core.sv
// Self-checking bench for aes_inv_core: GF(2^8)-derived AES model, cycle-level
// expectation of done/plaintext, FIPS-197 literal vectors and randomized traffic.
module tb_aes_inv_core;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] cyphertext = '0;
    logic         done;
    logic [127:0] plaintext;

    aes_inv_core dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .key        (key),
        .cyphertext (cyphertext),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

`ifdef AES_INV_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] B_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] B_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] B_PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] C_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899AABBCCDDEEFF;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) begin
            t = w[40 + i/4];
            s[i] = ct[127-8*i -: 8] ^ t[31-8*(i%4) -: 8];
        end
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++) begin
                t = w[4*rnd + c];
                for (int r = 0; r < 4; r++)
                    n[4*c+r] = isb[s[4*((c - r + 4) % 4) + r]] ^ t[31-8*r -: 8];
            end
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (rnd > 0) begin
                    s[4*c]   = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
                    s[4*c+1] = gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
                    s[4*c+2] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
                    s[4*c+3] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- cycle-level expectation ----------------
    logic [127:0] exp_q [$];
    bit           m_busy = 1'b0;
    int           m_cnt = 0;
    bit           m_done = 1'b0;
    logic [127:0] m_pt = '0;
    bit           m_load_q = 1'b0;
    bit           m_valid = 1'b0;
    logic [127:0] m_tag = '0;
    logic [127:0] m_key = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_cnt = 0; m_done = 1'b0; m_pt = '0;
            m_load_q = 1'b0; m_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (!m_busy && load && !m_load_q) begin
                exp_q.push_back(model_decrypt(key, cyphertext));
                m_cnt  = (CACHE && m_valid && key == m_tag) ? 11 : 21;
                m_key  = key;
                m_busy = 1'b1; m_done = 1'b0; m_pt = '0;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_pt = exp_q.pop_front();
                    m_valid = 1'b1; m_tag = m_key;
                end
            end
            m_load_q = load;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (done !== m_done || plaintext !== m_pt) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t done=%b exp=%b pt=%h exp=%h",
                         $time, done, m_done, plaintext, m_pt);
            end
        end
    end

    // ---------------- driver and check tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Load stays high for `pulse` edges starting at the start edge; an optional second
    // rising edge appears glitch_at edges later with a different block. exp_lat=0 skips checks.
    task automatic run_op(input logic [127:0] k, input logic [127:0] ct, input int pulse,
                          input int glitch_at, input int exp_lat, input logic [127:0] exp_pt,
                          input string name);
        int lat;
        int done_lat;
        key = k; cyphertext = ct; load = 1'b1;
        tick(1);
        lat = 0;
        done_lat = -1;
        while (lat < 80 && (done_lat < 0 || lat < pulse)) begin
            load = (lat + 1 < pulse) || (lat + 1 == glitch_at);
            if (lat + 1 == glitch_at) cyphertext = ~ct;
            tick(1);
            lat++;
            if (done_lat < 0 && done) done_lat = lat;
        end
        load = 1'b0;
        if (exp_lat > 0) begin
            check_int({name, "_latency"}, done_lat, exp_lat);
            check128({name, "_plaintext"}, plaintext, exp_pt);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] rk;
        logic [127:0] rc;
        build_tables();
        check128("model_fips_b", model_decrypt(B_KEY, B_CT), B_PT);
        check128("model_fips_c1", model_decrypt(C_KEY, C_CT), C_PT);

        tick(3);
        chk_en = 1'b1;
        reset = 1'b0;
        check128("reset_plaintext", plaintext, 128'h0);
        check_int("reset_done", int'(done), 0);
        tick(2);

        run_op(B_KEY, B_CT, 2, -1, 21, B_PT, "fips_b");
        tick(2);
        run_op(C_KEY, C_CT, 1, -1, 21, C_PT, "fips_c1");
        tick(1);
        do_reset(1);
        run_op(C_KEY, C_CT, 2, 5, 21, C_PT, "ignored_edge");
        tick(3);

        key = C_KEY; cyphertext = C_CT; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(11);
        reset = 1'b1;
        load = 1'b1;
        tick(1);
        check_int("midop_reset_done", int'(done), 0);
        check128("midop_reset_plaintext", plaintext, 128'h0);
        reset = 1'b0;
        run_op(C_KEY, C_CT, 2, -1, 21, C_PT, "after_reset");
        tick(2);

        do_reset(1);
        run_op(B_KEY, B_CT, 40, -1, 21, B_PT, "held_load");
        check_int("held_load_done_stays", int'(done), 1);
        tick(3);

        do_reset(1);
        run_op(C_KEY, C_CT, 2, -1, 21, C_PT, "cache_first");
        run_op(C_KEY, C_CT, 2, -1, CACHE ? 11 : 21, C_PT, "cache_second");
        run_op(B_KEY, B_CT, 2, -1, 21, B_PT, "cache_newkey");
        tick(2);

        rk = '0;
        for (int n = 0; n < 30; n++) begin
            if (n == 0 || $urandom_range(0, 3) != 0)
                rk = {$urandom, $urandom, $urandom, $urandom};
            rc = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin
                key = rk; cyphertext = rc; load = 1'b1;
                tick(1);
                load = 1'b0;
                tick($urandom_range(1, 20));
                load = 1'($urandom_range(0, 1));
                do_reset(1);
                load = 1'b0;
            end else begin
                run_op(rk, rc, $urandom_range(1, 4),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(6, 20) : -1, 0, '0, "rand");
            end
            tick($urandom_range(0, 3));
        end

        tick(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
